// File: rtl/dkong_noise_sfx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dkong_noise_sfx
// Brief    : Tick-driven XNOR LFSR noise source, noise prescaler and
//            per-channel decaying envelopes with a noise-gated digital mix.
//            Optional macro DKONG_NOISE_SFX_HOLD_EN adds a HOLD state.
// Revision : 1.0 - initial release
// ============================================================================
module dkong_noise_sfx #(
  parameter int LFSR_W  = 24,
  parameter int TAP_A   = 23,
  parameter int TAP_B   = 10,
  parameter int DIV_W   = 3,
  parameter int NUM_CH  = 3,
  parameter int ENV_W   = 8,
  parameter int DECAY_W = 12
) (
  input  logic                              masterclk,
  input  logic                              rst_n,
  input  logic                              tick,
  input  logic [NUM_CH-1:0]                 trig,
  input  logic [NUM_CH*DECAY_W-1:0]         decay_rate,
  output logic [LFSR_W-1:0]                 lfsr_q,
  output logic                              noise_raw,
  output logic                              noise_bit,
  output logic [NUM_CH*ENV_W-1:0]           ch_level,
  output logic [NUM_CH-1:0]                 busy,
  output logic [ENV_W+$clog2(NUM_CH)-1:0]   mix_out
);

  localparam int c_MIX_W = ENV_W + $clog2(NUM_CH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DECAY = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  logic                r_armed;
  logic                r_tick_d;
  logic                r_noise_raw_d;
  logic [NUM_CH-1:0]   r_trig_d;
  logic [LFSR_W-1:0]   r_lfsr;
  logic [DIV_W-1:0]    r_cntr;
  logic [c_MIX_W-1:0]  r_mix;
  logic [c_MIX_W-1:0]  w_mix;
  logic                w_tick_ev;
  logic [NUM_CH-1:0]   w_trig_ev;

  // r_armed masks the first clock after reset so inputs already high when
  // reset releases are not mistaken for fresh rising edges.
  assign w_tick_ev = r_armed & tick & ~r_tick_d;
  assign w_trig_ev = {NUM_CH{r_armed}} & trig & ~r_trig_d;
  assign noise_raw = r_lfsr[TAP_A] ^ r_lfsr[TAP_B];
  assign noise_bit = r_cntr[DIV_W-1];
  assign lfsr_q    = r_lfsr;
  assign mix_out   = r_mix;

  always_ff @(posedge masterclk or negedge rst_n) begin
    if (!rst_n) begin
      r_armed       <= 1'b0;
      r_tick_d      <= 1'b0;
      r_trig_d      <= '0;
      r_noise_raw_d <= 1'b0;
      r_lfsr        <= '0;
      r_cntr        <= '0;
      r_mix         <= '0;
    end else begin
      r_armed       <= 1'b1;
      r_tick_d      <= tick;
      r_trig_d      <= trig;
      r_noise_raw_d <= noise_raw;
      r_mix         <= w_mix;
      if (w_tick_ev)
        r_lfsr <= {r_lfsr[LFSR_W-2:0], ~noise_raw};
      if (noise_raw & ~r_noise_raw_d)
        r_cntr <= r_cntr + DIV_W'(1);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      state_t             r_state;
      state_t             w_state_nxt;
      logic [ENV_W-1:0]   r_level;
      logic [ENV_W-1:0]   w_level_nxt;
      logic [DECAY_W-1:0] r_rcnt;
      logic [DECAY_W-1:0] w_rcnt_nxt;
      logic [DECAY_W-1:0] w_rate;

      assign w_rate = decay_rate[gi*DECAY_W +: DECAY_W];

      always_ff @(posedge masterclk or negedge rst_n) begin
        if (!rst_n) begin
          r_state <= ST_IDLE;
          r_level <= '0;
          r_rcnt  <= '0;
        end else begin
          r_state <= w_state_nxt;
          r_level <= w_level_nxt;
          r_rcnt  <= w_rcnt_nxt;
        end
      end

      always_comb begin
        w_state_nxt = r_state;
        w_level_nxt = r_level;
        w_rcnt_nxt  = r_rcnt;
        if (w_trig_ev[gi]) begin
          w_level_nxt = '1;
          w_rcnt_nxt  = '0;
`ifdef DKONG_NOISE_SFX_HOLD_EN
          w_state_nxt = ST_HOLD;
`else
          w_state_nxt = ST_DECAY;
`endif
        end else begin
          case (r_state)
            ST_DECAY: begin
              if (w_tick_ev) begin
                if (r_rcnt == w_rate) begin
                  w_rcnt_nxt  = '0;
                  w_level_nxt = r_level - ENV_W'(1);
                  if (r_level == ENV_W'(1))
                    w_state_nxt = ST_IDLE;
                end else begin
                  w_rcnt_nxt = r_rcnt + DECAY_W'(1);
                end
              end
            end
            ST_HOLD: begin
              w_level_nxt = '1;
              if (!trig[gi]) begin
                w_state_nxt = ST_DECAY;
                w_rcnt_nxt  = '0;
              end
            end
            default: w_state_nxt = ST_IDLE;
          endcase
        end
      end

      assign ch_level[gi*ENV_W +: ENV_W] = r_level;
      assign busy[gi] = (r_state != ST_IDLE);
    end
  endgenerate

  always_comb begin
    w_mix = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (noise_bit)
        w_mix = w_mix + c_MIX_W'(ch_level[i*ENV_W +: ENV_W]);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dkong_noise_sfx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_dkong_noise_sfx
// Brief    : Directed and randomized bench for dkong_noise_sfx against an
//            arithmetic reference model of the noise and envelope behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dkong_noise_sfx;

  logic        masterclk = 1'b0;
  logic        rst_n;
  logic        tick;
  logic [2:0]  trig;
  logic [35:0] decay_rate;
  logic [23:0] lfsr_q;
  logic        noise_raw;
  logic        noise_bit;
  logic [23:0] ch_level;
  logic [2:0]  busy;
  logic [9:0]  mix_out;

  int n_err = 0;
  int n_chk = 0;

  // Reference model state, plain integers
  int m_lfsr, m_cntr, m_mix;
  int m_nr_d, m_tick_d, m_armed;
  int m_trig_d [3];
  int m_lvl [3];
  int m_cnt [3];
  int m_mode [3];   // 0 idle, 1 decaying, 2 held at max

  dkong_noise_sfx dut (
    .masterclk  (masterclk),
    .rst_n      (rst_n),
    .tick       (tick),
    .trig       (trig),
    .decay_rate (decay_rate),
    .lfsr_q     (lfsr_q),
    .noise_raw  (noise_raw),
    .noise_bit  (noise_bit),
    .ch_level   (ch_level),
    .busy       (busy),
    .mix_out    (mix_out)
  );

  always #5 masterclk = ~masterclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int m_noise();
    return ((m_lfsr / (1 << 23)) % 2) ^ ((m_lfsr / (1 << 10)) % 2);
  endfunction

  task automatic model_reset();
    m_lfsr = 0; m_cntr = 0; m_mix = 0;
    m_nr_d = 0; m_tick_d = 0; m_armed = 0;
    for (int i = 0; i < 3; i++) begin
      m_trig_d[i] = 0; m_lvl[i] = 0; m_cnt[i] = 0; m_mode[i] = 0;
    end
  endtask

  task automatic model_clock();
    int tev, nr, mixn, rate, tr, now;
    tev  = (m_armed != 0) && tick && (m_tick_d == 0);
    nr   = m_noise();
    mixn = 0;
    for (int i = 0; i < 3; i++)
      if (m_cntr >= 4) mixn += m_lvl[i];
    if (nr == 1 && m_nr_d == 0) m_cntr = (m_cntr + 1) % 8;
    m_nr_d = nr;
    if (tev) m_lfsr = (m_lfsr * 2 + (1 - nr)) % (1 << 24);
    for (int i = 0; i < 3; i++) begin
      now  = int'(trig[i]);
      tr   = (m_armed != 0) && now == 1 && m_trig_d[i] == 0;
      rate = int'(decay_rate[i*12 +: 12]);
      if (tr) begin
        m_lvl[i] = 255;
        m_cnt[i] = 0;
`ifdef DKONG_NOISE_SFX_HOLD_EN
        m_mode[i] = 2;
`else
        m_mode[i] = 1;
`endif
      end else if (m_mode[i] == 1 && tev) begin
        if (m_cnt[i] == rate) begin
          m_cnt[i] = 0;
          m_lvl[i] = m_lvl[i] - 1;
          if (m_lvl[i] == 0) m_mode[i] = 0;
        end else begin
          m_cnt[i] = (m_cnt[i] + 1) % 4096;
        end
      end else if (m_mode[i] == 2 && now == 0) begin
        m_mode[i] = 1;
        m_cnt[i]  = 0;
      end
      m_trig_d[i] = now;
    end
    m_tick_d = int'(tick);
    m_armed  = 1;
    m_mix    = mixn;
  endtask

  task automatic compare_all();
    int mb;
    mb = 0;
    check_eq("lfsr_q", lfsr_q, m_lfsr);
    check_eq("noise_raw", noise_raw, m_noise());
    check_eq("noise_bit", noise_bit, (m_cntr >= 4) ? 1 : 0);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("ch_level%0d", i), ch_level[i*8 +: 8], m_lvl[i]);
      if (m_mode[i] != 0) mb += (1 << i);
    end
    check_eq("busy", busy, mb);
    check_eq("mix_out", mix_out, m_mix);
  endtask

  task automatic step(input logic t, input logic [2:0] tr);
    tick = t;
    trig = tr;
    @(posedge masterclk);
    model_clock();
    #1;
    compare_all();
  endtask

  task automatic tick_pulse(input int n, input logic [2:0] tr);
    for (int k = 0; k < n; k++) begin
      step(1'b1, tr);
      step(1'b0, tr);
    end
  endtask

  initial begin
    int guard;
    rst_n = 1'b0; tick = 1'b0; trig = 3'b000; decay_rate = '0;
    model_reset();
    repeat (3) @(posedge masterclk);
    #1;
    compare_all();
    rst_n = 1'b1;
    step(1'b0, 3'b000);

    // LFSR sequence from reset
    tick_pulse(1, 3'b000);
    check_eq("lfsr_1tick", lfsr_q, 24'h000001);
    tick_pulse(10, 3'b000);
    check_eq("lfsr_11tick", lfsr_q, 24'h0007FF);
    check_eq("noise_raw_11", noise_raw, 1);
    tick_pulse(1, 3'b000);
    check_eq("lfsr_12tick", lfsr_q, 24'h000FFE);

    // Decay with rate 2 on channel 0
    decay_rate = 36'h000_000_002;
    step(1'b0, 3'b001);
    check_eq("dec_start_lvl", ch_level[7:0], 255);
    check_eq("dec_start_busy", busy[0], 1);
    step(1'b0, 3'b000);
    tick_pulse(3, 3'b000);
    check_eq("dec_3tick", ch_level[7:0], 254);
    tick_pulse(761, 3'b000);
    check_eq("dec_764tick", ch_level[7:0], 1);
    tick_pulse(1, 3'b000);
    check_eq("dec_765tick", ch_level[7:0], 0);
    check_eq("dec_765_busy", busy[0], 0);

    // Rate 0 and retrigger coinciding with a tick event
    decay_rate = '0;
    step(1'b0, 3'b001);
    step(1'b0, 3'b000);
    tick_pulse(100, 3'b000);
    check_eq("r0_100tick", ch_level[7:0], 155);
    step(1'b1, 3'b001);
    check_eq("retrig_wins", ch_level[7:0], 255);
    step(1'b0, 3'b000);

    // Trigger held high across ticks
    step(1'b0, 3'b010);
    tick_pulse(50, 3'b010);
`ifdef DKONG_NOISE_SFX_HOLD_EN
    check_eq("hold_50tick", ch_level[15:8], 255);
`else
    check_eq("held_50tick", ch_level[15:8], 205);
`endif
    step(1'b0, 3'b000);
    tick_pulse(5, 3'b000);
`ifdef DKONG_NOISE_SFX_HOLD_EN
    check_eq("hold_release", ch_level[15:8], 250);
`else
    check_eq("held_release", ch_level[15:8], 200);
`endif

    // Mix: all channels at max, wait for the prescaler MSB
    decay_rate = {3{12'hFFF}};
    step(1'b0, 3'b111);
    step(1'b0, 3'b000);
    guard = 0;
    while (m_cntr < 4 && guard < 600) begin
      tick_pulse(1, 3'b000);
      guard++;
    end
    check_eq("nb_rise_wait", (guard < 600) ? 1 : 0, 1);
    step(1'b0, 3'b000);
    check_eq("mix_full", mix_out, 765);
    guard = 0;
    while (m_cntr >= 4 && guard < 600) begin
      tick_pulse(1, 3'b000);
      guard++;
    end
    check_eq("nb_fall_wait", (guard < 600) ? 1 : 0, 1);
    step(1'b0, 3'b000);
    check_eq("mix_zero", mix_out, 0);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      logic [2:0] tr;
      if (c % 256 == 0)
        for (int i = 0; i < 3; i++)
          decay_rate[i*12 +: 12] = 12'($urandom_range(0, 3));
      tr = trig;
      for (int i = 0; i < 3; i++)
        if ($urandom_range(0, 63) == 0) tr[i] = ~tr[i];
      step(1'($urandom_range(0, 1)), tr);
    end

    // Asynchronous reset mid-effect, inputs held high through release
    step(1'b0, 3'b000);
    step(1'b0, 3'b111);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    check_eq("rst_async_lvl", ch_level, 0);
    @(posedge masterclk);
    #1;
    rst_n = 1'b1;
    step(1'b1, 3'b111);
    step(1'b1, 3'b111);
    check_eq("rst_held_busy", busy, 0);
    check_eq("rst_held_lfsr", lfsr_q, 0);
    step(1'b0, 3'b000);
    step(1'b0, 3'b111);
    check_eq("rst_refire_busy", busy, 3'b111);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
